// File: rtl/snes_serializer.sv
// SNES controller emulator: answers the console's latch/clock protocol with a 16-bit button word.
// Latency: a synchronised snes_clk rise updates snes_data within SYNC_STAGES+2 clk cycles.
// Backpressure: none; the console paces the frame, and edges outside a valid frame are ignored.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   data_in     button word, active-high pressed (bits 11:0 used, 15:12 forced released)
//   snes_latch  console latch line (asynchronous)
//   snes_clk    console serial clock line (asynchronous)
//   snes_data   serial data to the console, active-low, registered
//   busy        high while a frame is being shifted
//   frame_done  one-cycle pulse when the 16th bit has been shifted out
//   bit_idx     index of the bit currently on snes_data (16 = past the end)
module snes_serializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        snes_latch,
    input  logic        snes_clk,
    output logic        snes_data,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  bit_idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Synchronizer chains plus one extra delay flop each for edge detection.
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic                   latch_dly_q;
    logic                   sclk_dly_q;

    logic latch_s;
    logic sclk_s;
    logic latch_rise;
    logic latch_fall;
    logic sclk_rise;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic        snes_data_q, snes_data_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic [15:0] load_word;
    logic        unused_data_hi;

    // Bits 15:12 are not real buttons; they always shift out as released.
    assign load_word      = {4'b0000, data_in[11:0]};
    assign unused_data_hi = ^data_in[15:12];

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_dly_q;
    assign latch_fall = ~latch_s & latch_dly_q;
    assign sclk_rise  = sclk_s & ~sclk_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_sync_q <= '0;
            sclk_sync_q  <= '0;
            latch_dly_q  <= 1'b0;
            sclk_dly_q   <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], snes_latch};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], snes_clk};
            latch_dly_q  <= latch_s;
            sclk_dly_q   <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= 16'h0000;
            bit_idx_q    <= 5'd0;
            snes_data_q  <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            snes_data_q  <= snes_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (latch_rise) begin
                    state_d   = LATCHED;
                    shift_d   = load_word;
                    bit_idx_d = 5'd0;
                end
            end

            LATCHED: begin
                // Transparent load: the word tracks data_in until the latch falls.
                shift_d   = load_word;
                bit_idx_d = 5'd0;
                if (latch_fall) begin
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // A latch rise outranks a simultaneous clock rise and aborts the frame.
                if (latch_rise) begin
                    state_d   = LATCHED;
                    shift_d   = load_word;
                    bit_idx_d = 5'd0;
                end else if (sclk_rise && !latch_s) begin
                    shift_d   = {1'b0, shift_q[15:1]};
                    bit_idx_d = bit_idx_q + 5'd1;
                    if (bit_idx_q == 5'd15) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end

            DONE: begin
                if (latch_rise) begin
                    state_d   = LATCHED;
                    shift_d   = load_word;
                    bit_idx_d = 5'd0;
                end
            end

            default: begin
                state_d   = IDLE;
                shift_d   = 16'h0000;
                bit_idx_d = 5'd0;
            end
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        busy_d      = (state_d == SHIFT);
        snes_data_d = (state_d == DONE) ? 1'b0 : ~shift_d[0];
    end

    assign snes_data  = snes_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_snes_serializer.sv
module tb_snes_serializer;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        snes_latch;
    logic        snes_clk;
    logic        snes_data;
    logic        busy;
    logic        frame_done;
    logic [4:0]  bit_idx;

    int checks;
    int errors;
    int fd_count;
    int fd0;

    snes_serializer #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_data  (snes_data),
        .busy       (busy),
        .frame_done (frame_done),
        .bit_idx    (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial level for the bit at index i of a loaded word.
    function automatic logic exp_data(input logic [15:0] w, input int i);
        if (i >= 16) return 1'b0;
        if (i >= 12) return 1'b1;
        return ~w[i];
    endfunction

    task automatic latch_pulse();
        snes_latch = 1'b1;
        wait_cycles(8);
        snes_latch = 1'b0;
        wait_cycles(8);
    endtask

    task automatic clk_pulse();
        snes_clk = 1'b1;
        wait_cycles(8);
        snes_clk = 1'b0;
        wait_cycles(8);
    endtask

    // Apply clock pulses numbered from..to and check the bit presented after each.
    task automatic run_pulses(input string tag, input logic [15:0] w, input int from, input int to);
        int idx;
        for (int k = from; k <= to; k++) begin
            clk_pulse();
            idx = (k > 16) ? 16 : k;
            check({tag, "_idx"},  {11'd0, bit_idx},   idx[15:0]);
            check({tag, "_data"}, {15'd0, snes_data}, {15'd0, exp_data(w, idx)});
            check({tag, "_busy"}, {15'd0, busy},      {15'd0, (idx < 16)});
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        fd_count   = 0;
        reset      = 1'b1;
        data_in    = 16'h0000;
        snes_latch = 1'b0;
        snes_clk   = 1'b0;

        // Reset state
        wait_cycles(4);
        check("rst_data", {15'd0, snes_data}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_fd",   {15'd0, frame_done}, 16'd0);
        check("rst_idx",  {11'd0, bit_idx}, 16'd0);
        reset = 1'b0;
        wait_cycles(4);
        check("idle_data", {15'd0, snes_data}, 16'd1);

        // Single button B; data_in changes mid-frame must not leak in
        data_in = 16'h0001;
        latch_pulse();
        fd0 = fd_count;
        check("b_busy0", {15'd0, busy}, 16'd1);
        check("b_idx0",  {11'd0, bit_idx}, 16'd0);
        check("b_data0", {15'd0, snes_data}, 16'd0);
        data_in = 16'hFFFE;
        run_pulses("b", 16'h0001, 1, 15);
        check("b_fd_before", (fd_count - fd0), 16'd0);
        run_pulses("b", 16'h0001, 16, 16);
        check("b_fd_once", (fd_count - fd0), 16'd1);

        // All pressed: unused bits still read released
        data_in = 16'hFFFF;
        latch_pulse();
        fd0 = fd_count;
        check("all_data0", {15'd0, snes_data}, 16'd0);
        run_pulses("all", 16'hFFFF, 1, 16);
        check("all_fd", (fd_count - fd0), 16'd1);

        // Overrun: 20 pulses, bit_idx saturates, single frame_done
        data_in = 16'h0A5A;
        latch_pulse();
        fd0 = fd_count;
        check("sat_data0", {15'd0, snes_data}, {15'd0, exp_data(16'h0A5A, 0)});
        run_pulses("sat", 16'h0A5A, 1, 20);
        check("sat_fd", (fd_count - fd0), 16'd1);

        // Abort after 7 bits, new frame with A pressed
        data_in = 16'h0001;
        latch_pulse();
        fd0 = fd_count;
        run_pulses("pre", 16'h0001, 1, 7);
        data_in    = 16'h0100;
        snes_latch = 1'b1;
        wait_cycles(8);
        check("ab_busy", {15'd0, busy}, 16'd0);
        check("ab_idx",  {11'd0, bit_idx}, 16'd0);
        check("ab_data", {15'd0, snes_data}, 16'd1);
        check("ab_nofd", (fd_count - fd0), 16'd0);
        snes_latch = 1'b0;
        wait_cycles(8);
        check("a_busy0", {15'd0, busy}, 16'd1);
        check("a_data0", {15'd0, snes_data}, 16'd1);
        run_pulses("a", 16'h0100, 1, 16);
        check("a_fd", (fd_count - fd0), 16'd1);

        // Reset after 5 shifts
        data_in = 16'h0003;
        latch_pulse();
        fd0 = fd_count;
        run_pulses("mid", 16'h0003, 1, 5);
        reset = 1'b1;
        wait_cycles(1);
        check("mr_busy", {15'd0, busy}, 16'd0);
        check("mr_data", {15'd0, snes_data}, 16'd1);
        check("mr_idx",  {11'd0, bit_idx}, 16'd0);
        check("mr_fd",   {15'd0, frame_done}, 16'd0);
        reset = 1'b0;
        wait_cycles(4);
        check("mr_nofd", (fd_count - fd0), 16'd0);
        data_in = 16'h0800;
        latch_pulse();
        check("r_data0", {15'd0, snes_data}, 16'd1);
        run_pulses("r", 16'h0800, 1, 16);
        check("r_fd", (fd_count - fd0), 16'd1);

        // Latch and clock rise together mid-frame: latch wins
        data_in = 16'h0001;
        latch_pulse();
        check("sim_data0", {15'd0, snes_data}, 16'd0);
        snes_latch = 1'b1;
        snes_clk   = 1'b1;
        wait_cycles(8);
        check("sim_idx",  {11'd0, bit_idx}, 16'd0);
        check("sim_busy", {15'd0, busy}, 16'd0);
        check("sim_data", {15'd0, snes_data}, 16'd0);
        snes_clk = 1'b0;
        wait_cycles(8);
        snes_clk = 1'b1;
        wait_cycles(8);
        check("lh_idx", {11'd0, bit_idx}, 16'd0);
        snes_clk = 1'b0;
        wait_cycles(8);
        snes_latch = 1'b0;
        wait_cycles(8);
        fd0 = fd_count;
        check("sim_busy1", {15'd0, busy}, 16'd1);
        check("sim_idx1",  {11'd0, bit_idx}, 16'd0);
        run_pulses("sim", 16'h0001, 1, 16);
        check("sim_fd", (fd_count - fd0), 16'd1);

        // Latch already high across reset is seen as a rise
        data_in    = 16'h0010;
        snes_latch = 1'b1;
        reset      = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(8);
        check("rl_busy_lat", {15'd0, busy}, 16'd0);
        snes_latch = 1'b0;
        wait_cycles(8);
        fd0 = fd_count;
        check("rl_busy", {15'd0, busy}, 16'd1);
        check("rl_data0", {15'd0, snes_data}, 16'd1);
        run_pulses("rl", 16'h0010, 1, 16);
        check("rl_fd", (fd_count - fd0), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snes_serializer.md
SNES_SERIALIZER -- requirements
Module: snes_serializer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer for snes_latch and snes_clk (legal 2..4).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  16  controller word, active-high pressed; bit 0 = B, 1 = Y, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right, 8 = A, 9 = X, 10 = L, 11 = R, 12-15 unused.
REQ-005 snes_latch  input  1  console latch line, asynchronous to clk.
REQ-006 snes_clk  input  1  console serial clock line, asynchronous to clk.
REQ-007 snes_data  output  1  serial data to console, active-low (0 = pressed).
REQ-008 busy  output  1  high while a frame is being shifted.
REQ-009 frame_done  output  1  one-cycle pulse when the 16th bit has been shifted out.
REQ-010 bit_idx  output  5  index of the bit currently on snes_data (0..16; 16 = past the end).

Function
REQ-011 snes_latch and snes_clk SHALL each pass through a SYNC_STAGES flop synchronizer; edge detection SHALL compare the last stage against one additional delay flop.
REQ-012 Loaded word SHALL be {4'b0000, data_in[11:0]}; bits 12-15 always shift out as not pressed (snes_data = 1).
REQ-013 snes_data SHALL be registered and equal to the inverted shift-register LSB in IDLE, LATCHED, and SHIFT.
REQ-014 FSM states SHALL be IDLE, LATCHED, SHIFT, and DONE.
REQ-015 IDLE: on a synced latch rise, go to LATCHED.
REQ-016 LATCHED: reload the shift register from data_in every cycle (transparent parallel load); bit_idx = 0; on a synced latch fall, go to SHIFT.
REQ-017 SHIFT: busy = 1; on each synced snes_clk rising edge, right-shift one bit (fill 0) and increment bit_idx.
REQ-018 SHIFT: when bit_idx reaches 16, go to DONE and assert frame_done for exactly that cycle.
REQ-019 DONE: snes_data = 0 (constant low, as a genuine controller after 16 bits); extra snes_clk edges SHALL be ignored and bit_idx SHALL hold at 16.
REQ-020 DONE: on a synced latch rise, go to LATCHED.
REQ-021 A synced latch rise in SHIFT SHALL abort the frame: go to LATCHED, no frame_done, busy = 0 next cycle.
REQ-022 snes_clk edges while synced latch is high SHALL be ignored.
REQ-023 Latch rise and clk rise detected in the same cycle: the latch rise wins and the clk edge is discarded.
REQ-024 snes_clk falling edges SHALL have no effect.
REQ-025 Latency: a snes_clk rise stable at the input SHALL change snes_data within SYNC_STAGES+2 clk cycles; snes_clk half-periods of at least SYNC_STAGES+3 clk cycles SHALL be guaranteed correct.
REQ-026 data_in changes outside LATCHED SHALL NOT affect the frame in flight.

Reset
REQ-027 While reset is high on a rising clk edge, the block SHALL set: state = IDLE, shift register = 0, synchronizer and delay flops = 0, snes_data = 1, busy = 0, frame_done = 0, bit_idx = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse.
REQ-029 After reset, a latch already high SHALL be recognised as a rise once synchronized.

Verification
REQ-030 Bench SHALL cover: data_in = 16'h0001, latch pulse, then 16 clk pulses -> snes_data sequence 0, 1×15; frame_done pulses once after the 16th rise; snes_data = 0 afterwards.
REQ-031 Bench SHALL cover: data_in = 16'hFFFF -> bits 0-11 read 0 and bits 12-15 read 1, confirming forced unused bits.
REQ-032 Bench SHALL cover: 20 clk pulses after one latch -> bit_idx saturates at 16, a single frame_done, snes_data stays 0.
REQ-033 Bench SHALL cover: latch re-asserted after 7 clk pulses with data_in changed to 16'h0100 -> abort with no frame_done; the new frame shifts A pressed at bit 8.
REQ-034 Bench SHALL cover: reset asserted after 5 shifts -> next cycle busy = 0, snes_data = 1, bit_idx = 0; the following latch/clock frame is correct.
REQ-035 Bench SHALL cover: latch and snes_clk rising in the same clk cycle -> LATCHED, bit_idx = 0, no shift.
